// File: rtl/lab3_mem_responder.sv
// Backing-memory responder: word array behind a val/rdy request/response pair, fixed response delay.
// Define LAB3_MEM_RAND_DELAY_EN to add 0..3 extra cycles of LFSR-driven delay per request.
module lab3_mem_responder #(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [76:0] req_msg,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [46:0] resp_msg
);

  localparam int unsigned IdxW   = $clog2(NUM_WORDS);
  localparam logic [4:0]  LatCnt = 5'(LATENCY);

  typedef enum logic [1:0] {StIdle, StDelay, StResp} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic        req_rdy_q;
  logic        resp_val_q;
  logic [46:0] resp_msg_q;

  logic [31:0] mem_q [NUM_WORDS];

  logic [2:0]      req_type;
  logic [7:0]      req_opaque;
  logic [31:0]     req_addr;
  logic [1:0]      req_len;
  logic [31:0]     req_data;
  logic [IdxW-1:0] idx;
  logic [31:0]     old_word;
  logic [31:0]     byte_mask;
  logic [31:0]     wr_word;
  logic [31:0]     rd_data;
  logic [46:0]     resp_d;
  logic            accept;
  logic            is_wr;
  logic            mem_we;
  logic [4:0]      lat_load;
  logic            unused_addr;

  assign req_type   = req_msg[76:74];
  assign req_opaque = req_msg[73:66];
  assign req_addr   = req_msg[65:34];
  assign req_len    = req_msg[33:32];
  assign req_data   = req_msg[31:0];

  // Upper address bits wrap; byte offset is ignored.
  assign idx         = req_addr[IdxW+1:2];
  assign unused_addr = ^{req_addr[31:IdxW+2], req_addr[1:0]};

  assign old_word = mem_q[idx];

  always_comb begin
    byte_mask = 32'hFFFF_FFFF;
    case (req_len)
      2'd1:    byte_mask = 32'h0000_00FF;
      2'd2:    byte_mask = 32'h0000_FFFF;
      2'd3:    byte_mask = 32'h00FF_FFFF;
      default: byte_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign accept  = req_val & req_rdy_q;
  assign is_wr   = (req_type == 3'd1) || (req_type == 3'd2);
  assign mem_we  = accept & is_wr;
  assign wr_word = (old_word & ~byte_mask) | (req_data & byte_mask);
  assign rd_data = (req_type == 3'd0) ? (old_word & byte_mask) : 32'h0;
  assign resp_d  = {req_type, req_opaque, 2'b00, req_len, rd_data};

`ifdef LAB3_MEM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lat_load = LatCnt + 5'(lfsr_q[1:0]);
`else
  assign lat_load = LatCnt;
`endif

  // Array is deliberately left out of reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
      resp_msg_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            resp_msg_q <= resp_d;
            cnt_q      <= lat_load;
            req_rdy_q  <= 1'b0;
            if (lat_load == 5'd0) begin
              state_q    <= StResp;
              resp_val_q <= 1'b1;
            end else begin
              state_q <= StDelay;
            end
          end
        end
        StDelay: begin
          if (cnt_q == 5'd1) begin
            state_q    <= StResp;
            resp_val_q <= 1'b1;
            cnt_q      <= 5'd0;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        StResp: begin
          if (resp_rdy) begin
            state_q    <= StIdle;
            resp_val_q <= 1'b0;
            req_rdy_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_rdy  = req_rdy_q;
  assign resp_val = resp_val_q;
  assign resp_msg = resp_msg_q;

endmodule

// File: tb/tb_lab3_mem_responder.sv
// Scoreboarded bench for lab3_mem_responder in its default fixed-latency build.
module tb_lab3_mem_responder;

  localparam int unsigned NW  = 256;
  localparam int unsigned LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [76:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [46:0] resp_msg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [46:0] exp_q [$];
  logic [31:0] mdl [NW];

  lab3_mem_responder #(
    .NUM_WORDS (NW),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference memory: byte-wise access, wrapping word index.
  function automatic logic [46:0] model(input logic [2:0] t, input logic [7:0] o,
                                        input logic [31:0] a, input logic [1:0] l,
                                        input logic [31:0] d);
    int          wi = int'((a >> 2) % NW);
    int          nb = (l == 2'd0) ? 4 : int'(l);
    logic [31:0] rd = 32'h0;
    for (int b = 0; b < nb; b++) begin
      if (t == 3'd0) rd[8*b +: 8] = mdl[wi][8*b +: 8];
      else if (t == 3'd1 || t == 3'd2) mdl[wi][8*b +: 8] = d[8*b +: 8];
    end
    return {t, o, 2'b00, l, rd};
  endfunction

  // Presents one request while the DUT is idle; it is accepted on the next rising edge.
  task automatic send_req(input logic [2:0] t, input logic [7:0] o, input logic [31:0] a,
                          input logic [1:0] l, input logic [31:0] d, input bit push);
    logic [46:0] e;
    e = model(t, o, a, l, d);
    if (push) exp_q.push_back(e);
    req_msg = {t, o, a, l, d};
    req_val = 1'b1;
    @(posedge clk);
    #1;
    req_val = 1'b0;
  endtask

  task automatic wait_resp(output logic [46:0] m, output bit ok);
    ok = 1'b0;
    m  = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (resp_val) begin
        m  = resp_msg;
        ok = 1'b1;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_req_rdy: got %b expected 1", req_rdy);
    end
    n_checks++;
    if (resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp_val: got %b expected 0", resp_val);
    end
    n_checks++;
    if (resp_msg !== 47'h0) begin
      n_fail++;
      $display("FAIL reset_resp_msg: got %h expected 0", resp_msg);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write_read;
    logic [46:0] got, e;
    bit          ok;
    send_req(3'd1, 8'h03, 32'h0000_0010, 2'd0, 32'hDEAD_BEEF, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("FAIL wr_resp: got %h expected %h timeout=%0d", got, e, !ok);
    end
    send_req(3'd0, 8'h04, 32'h0000_0010, 2'd0, 32'h0, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e || got[31:0] !== 32'hDEAD_BEEF || got[43:36] !== 8'h04) begin
      n_fail++;
      $display("FAIL rd_resp: got %h expected %h timeout=%0d", got, e, !ok);
    end
  endtask

  task automatic test_latency;
    logic [46:0] e;
    send_req(3'd0, 8'h11, 32'h0000_0010, 2'd0, 32'h0, 1'b1);
    for (int i = 1; i <= int'(LAT) + 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_val !== (i == int'(LAT) + 1) || req_rdy !== (i == int'(LAT) + 2)) begin
        n_fail++;
        $display("FAIL latency_c%0d: got val=%b rdy=%b expected val=%b rdy=%b", i, resp_val,
                 req_rdy, (i == int'(LAT) + 1), (i == int'(LAT) + 2));
      end
      if (i == int'(LAT) + 1) begin
        e = exp_q.pop_front();
        n_checks++;
        if (resp_msg !== e) begin
          n_fail++;
          $display("FAIL latency_msg: got %h expected %h", resp_msg, e);
        end
      end
    end
  endtask

  task automatic test_partial_wrap;
    logic [46:0] got, e;
    bit          ok;
    send_req(3'd2, 8'h20, 32'h0000_0020, 2'd0, 32'h1122_3344, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("FAIL init_resp: got %h expected %h timeout=%0d", got, e, !ok);
    end
    send_req(3'd1, 8'h21, 32'h0000_0020 + NW * 4, 2'd1, 32'h0000_00FF, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin
      n_fail++;
      $display("FAIL wrap_wr_resp: got %h expected %h timeout=%0d", got, e, !ok);
    end
    send_req(3'd0, 8'h22, 32'h0000_0020, 2'd2, 32'h0, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e || got[31:0] !== 32'h0000_33FF) begin
      n_fail++;
      $display("FAIL rd_len2: got %h expected %h timeout=%0d", got, e, !ok);
    end
    send_req(3'd0, 8'h23, 32'h0000_0020, 2'd0, 32'h0, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e || got[31:0] !== 32'h1122_33FF) begin
      n_fail++;
      $display("FAIL rd_len0: got %h expected %h timeout=%0d", got, e, !ok);
    end
  endtask

  task automatic test_backpressure;
    logic [46:0] held, e;
    bit          ok;
    resp_rdy = 1'b0;
    send_req(3'd0, 8'h30, 32'h0000_0010, 2'd0, 32'h0, 1'b1);
    ok   = 1'b0;
    held = '0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (resp_val) begin
        held = resp_msg;
        ok   = 1'b1;
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || held !== e) begin
      n_fail++;
      $display("FAIL bp_msg: got %h expected %h timeout=%0d", held, e, !ok);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (resp_msg !== e || resp_val !== 1'b1 || req_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_c%0d: got msg=%h val=%b rdy=%b expected msg=%h val=1 rdy=0", i,
                 resp_msg, resp_val, req_rdy, e);
      end
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got val=%b rdy=%b expected val=0 rdy=1", resp_val, req_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_single: got val=%b expected 0", resp_val);
    end
  endtask

  task automatic test_reset_mid;
    logic [46:0] got, e;
    bit          seen;
    bit          ok;
    send_req(3'd0, 8'h40, 32'h0000_0010, 2'd0, 32'h0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got rdy=%b val=%b expected rdy=1 val=0", req_rdy, resp_val);
    end
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_val !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rst_no_resp: got stray resp_val expected none");
    end
    send_req(3'd0, 8'h41, 32'h0000_0010, 2'd0, 32'h0, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e || got[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL rst_keep_data: got %h expected %h timeout=%0d", got, e, !ok);
    end
  endtask

  task automatic test_unknown_type;
    logic [46:0] got, e;
    bit          ok;
    send_req(3'd3, 8'h50, 32'h0000_0010, 2'd0, 32'hFFFF_FFFF, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e || got[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL unk_resp: got %h expected %h timeout=%0d", got, e, !ok);
    end
    send_req(3'd0, 8'h51, 32'h0000_0010, 2'd0, 32'h0, 1'b1);
    wait_resp(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e || got[31:0] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL unk_unchanged: got %h expected %h timeout=%0d", got, e, !ok);
    end
  endtask

  task automatic test_back_to_back;
    logic [46:0] got, e;
    bit          ok;
    logic [2:0]  t;
    logic [31:0] a;
    for (int i = 0; i < 20; i++) begin
      a = 32'h0000_0100 + 32'(($urandom % 8) * 4);
      t = (i < 8) ? 3'd1 : 3'($urandom_range(0, 2));
      if (i < 8) a = 32'h0000_0100 + 32'(i * 4);
      send_req(t, 8'(i), a, (i < 8) ? 2'd0 : 2'($urandom % 4), $urandom, 1'b1);
      wait_resp(got, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || got !== e) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h expected %h timeout=%0d", i, got, e, !ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_latency();
    test_partial_wrap();
    test_backpressure();
    test_reset_mid();
    test_unknown_type();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
